instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 154 +++++++++++++++
 tb/tb_instruction_encoder.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Encodes ALU-style requests into RV32 R/I-type words, buffers them in a small FIFO
// and streams them to instruction memory at an auto-incrementing word address.
module instruction_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [3:0]                    opSelect,
    input  logic [4:0]                    rd,
    input  logic [4:0]                    rs1,
    input  logic [4:0]                    rs2,
    input  logic [31:0]                   immediateVal,
    input  logic                          reqValid,
    output logic                          reqReady,
    input  logic                          loadStart,
    input  logic [31:0]                   startAddress,
    output logic                          memWriteEnable,
    output logic [31:0]                   memAddress,
    output logic [31:0]                   memData,
    input  logic                          memReady,
    input  logic                          clearError,
    output logic                          error,
    output logic [1:0]                    errorCode,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        addr_q, addr_d;
    logic               error_q, error_d;
    logic [1:0]         error_code_q, error_code_d;
    logic [31:0]        fifo_q [FIFO_DEPTH];

    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               is_itype, op_invalid, imm_bad;
    logic [31:0]        word;
    logic               fifo_full, fifo_empty;
    logic               attempt, reject, push, pop;

    always_comb begin
        funct3     = 3'd0;
        funct7     = 7'h00;
        is_itype   = 1'b0;
        op_invalid = 1'b0;
        case (opSelect)
            4'd0:    is_itype = 1'b1;
            4'd1:    funct7 = 7'h00;
            4'd2:    funct7 = 7'h20;
            4'd3:    funct7 = 7'h01;
            4'd4:    begin funct3 = 3'd4; funct7 = 7'h01; end
            4'd5:    begin funct3 = 3'd5; funct7 = 7'h01; end
            4'd6:    begin funct3 = 3'd6; funct7 = 7'h01; end
            4'd7:    begin funct3 = 3'd7; funct7 = 7'h01; end
            4'd8:    begin funct3 = 3'd2; is_itype = 1'b1; end
            4'd9:    begin funct3 = 3'd3; is_itype = 1'b1; end
            4'd10:   funct3 = 3'd2;
            4'd11:   funct3 = 3'd3;
            default: op_invalid = 1'b1;
        endcase
        // A 12-bit signed immediate requires bits 31:11 to be a pure sign extension
        imm_bad = is_itype && !((&immediateVal[31:11]) || !(|immediateVal[31:11]));
        word    = is_itype ? {immediateVal[11:0], rs1, funct3, rd, 7'h13}
                           : {funct7, rs2, rs1, funct3, rd, 7'h33};
    end

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (loadStart)  state_d = RUN;
            RUN:     if (reject)     state_d = HALT;
            HALT:    if (clearError) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reqReady       = (state_q == RUN) && !fifo_full;
        memWriteEnable = !fifo_empty;
        memData        = fifo_empty ? '0 : fifo_q[rd_ptr_q];
        memAddress     = addr_q;
        error          = error_q;
        errorCode      = error_code_q;
        fifoCount      = count_q;
    end

    always_comb begin
        attempt  = reqValid && reqReady;
        reject   = attempt && (op_invalid || imm_bad);
        push     = attempt && !reject;
        pop      = !fifo_empty && memReady;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);

        addr_d = addr_q;
        if (loadStart)
            addr_d = {startAddress[31:2], 2'b00};
        else if (pop)
            addr_d = addr_q + 32'd4;

        // A rejection in the same cycle as clearError wins
        error_d      = error_q;
        error_code_d = error_code_q;
        if (reject) begin
            error_d      = 1'b1;
            error_code_d = op_invalid ? 2'd1 : 2'd2;
        end else if (clearError) begin
            error_d      = 1'b0;
            error_code_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            error_q      <= 1'b0;
            error_code_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            error_q      <= error_d;
            error_code_q <= error_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= word;
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized self-checking bench for instruction_encoder against a queue-based
// behavioural model of the encoder, FIFO, address counter and error/halt behaviour.
module tb_instruction_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  opSelect;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] immediateVal;
    logic        reqValid, reqReady;
    logic        loadStart;
    logic [31:0] startAddress;
    logic        memWriteEnable;
    logic [31:0] memAddress, memData;
    logic        memReady;
    logic        clearError;
    logic        error;
    logic [1:0]  errorCode;
    logic [2:0]  fifoCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_q[$];
    logic [31:0] m_addr;
    int          m_mode;
    logic        m_err;
    logic [1:0]  m_code;
    logic [31:0] exp_data[$], exp_addr[$], act_data[$], act_addr[$];

    instruction_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .opSelect(opSelect), .rd(rd), .rs1(rs1), .rs2(rs2),
        .immediateVal(immediateVal), .reqValid(reqValid), .reqReady(reqReady),
        .loadStart(loadStart), .startAddress(startAddress), .memWriteEnable(memWriteEnable),
        .memAddress(memAddress), .memData(memData), .memReady(memReady),
        .clearError(clearError), .error(error), .errorCode(errorCode), .fifoCount(fifoCount)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [4:0] d,
                                               input logic [4:0] s1, input logic [4:0] s2,
                                               input logic [31:0] imm);
        logic [31:0] f3, f7;
        case (op)
            4'd4: f3 = 32'd4;
            4'd5: f3 = 32'd5;
            4'd6: f3 = 32'd6;
            4'd7: f3 = 32'd7;
            4'd8, 4'd10: f3 = 32'd2;
            4'd9, 4'd11: f3 = 32'd3;
            default: f3 = 32'd0;
        endcase
        f7 = (op == 4'd2) ? 32'h20 : (op >= 4'd3 && op <= 4'd7) ? 32'h01 : 32'h00;
        if (op == 4'd0 || op == 4'd8 || op == 4'd9)
            return ((imm & 32'hFFF) << 20) | ({27'b0, s1} << 15) | (f3 << 12) | ({27'b0, d} << 7) | 32'h13;
        return (f7 << 25) | ({27'b0, s2} << 20) | ({27'b0, s1} << 15) | (f3 << 12) | ({27'b0, d} << 7) | 32'h33;
    endfunction

    function automatic int ref_bad(input logic [3:0] op, input logic [31:0] imm);
        if (op > 4'd11) return 1;
        if ((op == 4'd0 || op == 4'd8 || op == 4'd9) && ($signed(imm) < -2048 || $signed(imm) > 2047))
            return 2;
        return 0;
    endfunction

    // Advance one clock, applying the current inputs to the model and logging writes.
    task automatic tick();
        bit m_ready, acc, pop;
        int code;
        m_ready = (m_mode == 1) && (m_q.size() < DEPTH);
        acc     = reqValid && m_ready;
        code    = acc ? ref_bad(opSelect, immediateVal) : 0;
        pop     = (m_q.size() != 0) && memReady;
        if (memWriteEnable && memReady) begin
            act_data.push_back(memData);
            act_addr.push_back(memAddress);
        end
        if (pop) begin
            exp_data.push_back(m_q.pop_front());
            exp_addr.push_back(m_addr);
        end
        if (loadStart) m_addr = startAddress & 32'hFFFFFFFC;
        else if (pop)  m_addr = m_addr + 32'd4;
        if (acc && code == 0) m_q.push_back(ref_encode(opSelect, rd, rs1, rs2, immediateVal));
        if (code != 0) begin m_err = 1'b1; m_code = code[1:0]; end
        else if (clearError) begin m_err = 1'b0; m_code = 2'd0; end
        if (m_mode == 0 && loadStart) m_mode = 1;
        else if (m_mode == 1 && code != 0) m_mode = 2;
        else if (m_mode == 2 && clearError) m_mode = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_addr = '0; m_mode = 0; m_err = 1'b0; m_code = 2'd0;
    endtask

    task automatic clear_log();
        exp_data.delete(); exp_addr.delete(); act_data.delete(); act_addr.delete();
    endtask

    task automatic drive_req(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [31:0] imm);
        opSelect = op; rd = d; rs1 = s1; rs2 = s2; immediateVal = imm; reqValid = 1'b1;
    endtask

    task automatic rand_valid_req();
        drive_req(4'($urandom_range(0, 11)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 32'($urandom_range(0, 4095)) - 32'd2048);
    endtask

    task automatic drain();
        int n = 0;
        reqValid = 1'b0; memReady = 1'b1; loadStart = 1'b0;
        while ((m_q.size() != 0 || memWriteEnable) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (m_q.size() != 0 || memWriteEnable) begin
            errors++;
            $display("FAIL drain_timeout: memWriteEnable=%b model_pending=%0d required both empty", memWriteEnable, m_q.size());
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({reqReady, memWriteEnable, memData, memAddress, fifoCount, error, errorCode} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b we=%b data=%h addr=%h cnt=%0d err=%b code=%0d required all 0",
                     reqReady, memWriteEnable, memData, memAddress, fifoCount, error, errorCode);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        tick(); tick();
        checks++;
        if (reqReady !== 1'b0) begin errors++; $display("FAIL idle_not_ready: reqReady=%b required 0", reqReady); end
    endtask

    task automatic test_known_words();
        clear_log();
        startAddress = 32'h100; loadStart = 1'b1; tick(); loadStart = 1'b0;
        memReady = 1'b1;
        checks++;
        if (reqReady !== 1'b1) begin errors++; $display("FAIL run_ready: reqReady=%b required 1", reqReady); end
        drive_req(4'd1, 5'd1, 5'd2, 5'd3, 32'd0); tick(); reqValid = 1'b0;
        checks++;
        if ({memWriteEnable, memAddress, memData} !== {1'b1, 32'h100, 32'h003100B3}) begin
            errors++; $display("FAIL add_word: we=%b addr=%h data=%h required 1 00000100 003100b3", memWriteEnable, memAddress, memData);
        end
        drive_req(4'd0, 5'd5, 5'd0, 5'd7, 32'hFFFFFFFF); tick();
        checks++;
        if ({memAddress, memData} !== {32'h104, 32'hFFF00293}) begin
            errors++; $display("FAIL addi_word: addr=%h data=%h required 00000104 fff00293", memAddress, memData);
        end
        drive_req(4'd2, 5'd1, 5'd2, 5'd3, 32'd0); tick();
        checks++;
        if ({memAddress, memData} !== {32'h108, 32'h403100B3}) begin
            errors++; $display("FAIL sub_word: addr=%h data=%h required 00000108 403100b3", memAddress, memData);
        end
        drive_req(4'd5, 5'd1, 5'd2, 5'd3, 32'd0); tick();
        checks++;
        if ({memAddress, memData} !== {32'h10C, 32'h023150B3}) begin
            errors++; $display("FAIL divu_word: addr=%h data=%h required 0000010c 023150b3", memAddress, memData);
        end
        drain();
        checks++;
        if (act_data.size() != 4 || act_data.size() != exp_data.size()) begin
            errors++; $display("FAIL known_count: writes=%0d required %0d", act_data.size(), exp_data.size());
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        memReady = 1'b0;
        for (int i = 0; i < 5; i++) begin rand_valid_req(); tick(); end
        reqValid = 1'b0;
        checks++;
        if (fifoCount !== 3'd4 || reqReady !== 1'b0) begin
            errors++; $display("FAIL full_fifo: cnt=%0d rdy=%b required 4 0", fifoCount, reqReady);
        end
        memReady = 1'b1; rand_valid_req();
        checks++;
        if (reqReady !== 1'b0) begin errors++; $display("FAIL full_pop_bypass: reqReady=%b required 0", reqReady); end
        tick();
        checks++;
        if (fifoCount !== 3'd3) begin errors++; $display("FAIL pop_count: cnt=%0d required 3", fifoCount); end
        rand_valid_req(); tick();
        checks++;
        if (fifoCount !== 3'd3) begin errors++; $display("FAIL push_pop_count: cnt=%0d required 3", fifoCount); end
        drain();
        checks++;
        if (act_data.size() !== exp_data.size()) begin
            errors++; $display("FAIL bp_write_count: got %0d required %0d", act_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
            checks++;
            if ({act_addr[i], act_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                errors++; $display("FAIL bp_write[%0d]: got %h@%h required %h@%h", i, act_data[i], act_addr[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_reject();
        logic [31:0] imms [4] = '{32'hFFFFF800, 32'h000007FF, 32'hFFFFF7FF, 32'h7FFFFFFF};
        clear_log();
        memReady = 1'b0;
        drive_req(4'd1, 5'd4, 5'd5, 5'd6, 32'd0); tick();
        drive_req(4'd8, 5'd1, 5'd2, 5'd0, 32'd2048); tick(); reqValid = 1'b0;
        checks++;
        if ({error, errorCode, reqReady, fifoCount} !== {1'b1, 2'd2, 1'b0, 3'd1}) begin
            errors++; $display("FAIL imm_reject: err=%b code=%0d rdy=%b cnt=%0d required 1 2 0 1", error, errorCode, reqReady, fifoCount);
        end
        memReady = 1'b1; tick();
        checks++;
        if ({fifoCount, error} !== {3'd0, 1'b1}) begin
            errors++; $display("FAIL halt_drain: cnt=%0d err=%b required 0 1", fifoCount, error);
        end
        clearError = 1'b1; tick(); clearError = 1'b0;
        checks++;
        if ({error, errorCode, reqReady} !== {1'b0, 2'd0, 1'b1}) begin
            errors++; $display("FAIL clear_error: err=%b code=%0d rdy=%b required 0 0 1", error, errorCode, reqReady);
        end
        drive_req(4'd13, 5'd1, 5'd1, 5'd1, 32'd0); clearError = 1'b1; tick(); reqValid = 1'b0; clearError = 1'b0;
        checks++;
        if ({error, errorCode, reqReady} !== {1'b1, 2'd1, 1'b0}) begin
            errors++; $display("FAIL reject_vs_clear: err=%b code=%0d rdy=%b required 1 1 0", error, errorCode, reqReady);
        end
        clearError = 1'b1; tick(); clearError = 1'b0;
        foreach (imms[k]) begin
            drive_req(4'd9, 5'd3, 5'd4, 5'd5, imms[k]); tick(); reqValid = 1'b0;
            checks++;
            if ({error, errorCode, fifoCount} !== {m_err, m_code, 3'(m_q.size())}) begin
                errors++; $display("FAIL imm_bound[%0d]: err=%b code=%0d cnt=%0d required %b %0d %0d",
                                   k, error, errorCode, fifoCount, m_err, m_code, m_q.size());
            end
            if (m_err) begin clearError = 1'b1; tick(); clearError = 1'b0; end
        end
        drain();
        checks++;
        if (act_data.size() !== exp_data.size()) begin
            errors++; $display("FAIL rej_write_count: got %0d required %0d", act_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
            checks++;
            if ({act_addr[i], act_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                errors++; $display("FAIL rej_write[%0d]: got %h@%h required %h@%h", i, act_data[i], act_addr[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_wrap();
        clear_log();
        memReady = 1'b1;
        startAddress = 32'hFFFFFFFF; loadStart = 1'b1; tick(); loadStart = 1'b0;
        rand_valid_req(); tick();
        rand_valid_req(); tick();
        drain();
        checks++;
        if (act_addr.size() !== 2) begin
            errors++; $display("FAIL wrap_count: got %0d required 2", act_addr.size());
        end else begin
            checks++;
            if ({act_addr[0], act_addr[1]} !== {32'hFFFFFFFC, 32'h0}) begin
                errors++; $display("FAIL wrap_addr: got %h,%h required fffffffc,00000000", act_addr[0], act_addr[1]);
            end
            checks++;
            if ({act_data[0], act_data[1]} !== {exp_data[0], exp_data[1]}) begin
                errors++; $display("FAIL wrap_data: got %h,%h required %h,%h", act_data[0], act_data[1], exp_data[0], exp_data[1]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin rand_valid_req(); tick(); end
        reqValid = 1'b0;
        checks++;
        if (fifoCount !== 3'd3) begin errors++; $display("FAIL pre_reset_count: cnt=%0d required 3", fifoCount); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({memWriteEnable, fifoCount, reqReady, memData, memAddress} !== '0) begin
            errors++; $display("FAIL async_reset: we=%b cnt=%0d rdy=%b data=%h addr=%h required all 0",
                               memWriteEnable, fifoCount, reqReady, memData, memAddress);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset(); clear_log();
        memReady = 1'b1; tick();
        checks++;
        if ({reqReady, memWriteEnable} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle: rdy=%b we=%b required 0 0", reqReady, memWriteEnable);
        end
        startAddress = 32'h0; loadStart = 1'b1; tick(); loadStart = 1'b0;
        checks++;
        if (reqReady !== 1'b1) begin errors++; $display("FAIL post_reset_run: reqReady=%b required 1", reqReady); end
    endtask

    task automatic test_random();
        clear_log();
        for (int c = 0; c < 400; c++) begin
            memReady   = ($urandom_range(0, 2) != 0);
            loadStart  = ($urandom_range(0, 24) == 0);
            startAddress = $urandom();
            clearError = (m_mode == 2) && ($urandom_range(0, 3) == 0);
            reqValid   = 1'b0;
            if ($urandom_range(0, 9) < 7) begin
                rand_valid_req();
                if ($urandom_range(0, 29) == 0) opSelect = 4'($urandom_range(12, 15));
                if ($urandom_range(0, 29) == 0) immediateVal = $urandom();
            end
            checks++;
            if ({reqReady, fifoCount, error, errorCode, memWriteEnable} !==
                {(m_mode == 1) && (m_q.size() < DEPTH), 3'(m_q.size()), m_err, m_code, m_q.size() != 0}) begin
                errors++; $display("FAIL rand_cycle[%0d]: rdy=%b cnt=%0d err=%b code=%0d we=%b required rdy=%b cnt=%0d err=%b code=%0d",
                                   c, reqReady, fifoCount, error, errorCode, memWriteEnable,
                                   (m_mode == 1) && (m_q.size() < DEPTH), m_q.size(), m_err, m_code);
            end
            tick();
        end
        clearError = 1'b0;
        drain();
        checks++;
        if (act_data.size() !== exp_data.size()) begin
            errors++; $display("FAIL rand_write_count: got %0d required %0d", act_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
            checks++;
            if ({act_addr[i], act_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                errors++; $display("FAIL rand_write[%0d]: got %h@%h required %h@%h", i, act_data[i], act_addr[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; opSelect = '0; rd = '0; rs1 = '0; rs2 = '0; immediateVal = '0;
        reqValid = 1'b0; loadStart = 1'b0; startAddress = '0; memReady = 1'b0; clearError = 1'b0;
        model_reset();
        test_reset();
        test_known_words();
        test_backpressure();
        test_reject();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
